// File: rtl/auth_response_gate_if.sv
// rtl/auth_response_gate_if.sv - request, comparator and response signals of auth_response_gate
interface auth_response_gate_if #(
  parameter int MAX_FAILS = 3
);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  logic              req_valid;
  logic              req_ready;
  logic              cmp_start;
  logic              cmp_done;
  logic              cmp_match;
  logic              resp_valid;
  logic              resp_grant;
  logic              locked;
  logic [FAIL_W-1:0] fail_count;

  modport slave (
    input  req_valid, cmp_done, cmp_match,
    output req_ready, cmp_start, resp_valid, resp_grant, locked, fail_count
  );

  modport master (
    output req_valid, cmp_done, cmp_match,
    input  req_ready, cmp_start, resp_valid, resp_grant, locked, fail_count
  );
endinterface

// File: rtl/auth_response_gate.sv
// rtl/auth_response_gate.sv - fixed-latency grant/deny release with consecutive-failure lockout
module auth_response_gate #(
  parameter int RESP_LATENCY   = 40,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  auth_response_gate_if.slave bus
);
  localparam int TIMER_MAX = (RESP_LATENCY > LOCKOUT_CYCLES) ? RESP_LATENCY : LOCKOUT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int FAIL_W    = $clog2(MAX_FAILS + 1);

  localparam logic [TIMER_W-1:0] LAT_LOAD   = TIMER_W'(RESP_LATENCY - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD  = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_LIMIT = FAIL_W'(MAX_FAILS);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CMP,
    HOLD,
    RESPOND,
    LOCKOUT
  } state_t;

  state_t              state, state_d;
  logic [TIMER_W-1:0]  timer, timer_d;
  logic                match_q, match_d;
  logic                first_q, first_d;
  logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
  logic                timer_zero;
  logic                req_ready;
  logic                cmp_start;
  logic                resp_valid;
  logic                resp_grant;
  logic                locked;

  assign timer_zero = (timer == '0);

  // ready is gated by reset_n directly so it is low for the whole reset pulse
  assign bus.req_ready  = req_ready & reset_n;
  assign bus.cmp_start  = cmp_start;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_grant = resp_grant;
  assign bus.locked     = locked;
  assign bus.fail_count = fail_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Shared latency/lockout timer, captured result, start flag and failure count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer   <= '0;
      match_q <= 1'b0;
      first_q <= 1'b0;
      fail_q  <= '0;
    end else begin
      timer   <= timer_d;
      match_q <= match_d;
      first_q <= first_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state and output decode; response timing depends only on the timer
  always_comb begin
    state_d    = state;
    timer_d    = timer_zero ? timer : timer - 1'b1;
    match_d    = match_q;
    first_d    = 1'b0;
    fail_d     = fail_q;
    fail_inc   = (fail_q == FAIL_LIMIT) ? fail_q : fail_q + 1'b1;
    req_ready  = 1'b0;
    cmp_start  = 1'b0;
    resp_valid = 1'b0;
    resp_grant = 1'b0;
    locked     = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          timer_d = LAT_LOAD;
          match_d = 1'b0;
          first_d = 1'b1;
          state_d = WAIT_CMP;
        end
      end

      WAIT_CMP: begin
        cmp_start = first_q;
        // a done landing on the last timer cycle still counts and goes straight to RESPOND
        if (bus.cmp_done) begin
          match_d = bus.cmp_match;
          state_d = timer_zero ? RESPOND : HOLD;
        end else if (timer_zero) begin
          state_d = RESPOND;
        end
      end

      HOLD: begin
        if (timer_zero) begin
          state_d = RESPOND;
        end
      end

      RESPOND: begin
        resp_valid = 1'b1;
        resp_grant = match_q;
        if (match_q) begin
          fail_d  = '0;
          state_d = IDLE;
        end else begin
          fail_d = fail_inc;
          if (fail_inc == FAIL_LIMIT) begin
            timer_d = LOCK_LOAD;
            state_d = LOCKOUT;
          end else begin
            state_d = IDLE;
          end
        end
      end

      LOCKOUT: begin
        locked = 1'b1;
        if (timer_zero) begin
          fail_d  = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: doc/auth_response_gate.md
# auth_response_gate

Downstream stage of the bit-serial password-hash comparator. It accepts authentication requests, starts the comparator, and captures its match result. It releases the grant/deny response at a fixed cycle count after acceptance, whatever the result or how early the comparator finished, so response timing does not leak match progress. It also counts consecutive failures and enforces a timed lockout.

## Interface
- RESP_LATENCY, 40: cycles from request acceptance to response; legal range 4..4095.
- MAX_FAILS, 3: consecutive failures that trigger lockout; ≥1.
- LOCKOUT_CYCLES, 1024: lockout duration in cycles; ≥1.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  upstream request present.
- req_ready  out  1  gate can accept a request.
- cmp_start  out  1  one-cycle start pulse to the comparator.
- cmp_done  in  1  comparator finished; qualifies cmp_match.
- cmp_match  in  1  comparator result (1 = hashes equal).
- resp_valid  out  1  one-cycle response strobe.
- resp_grant  out  1  access granted; meaningful only with resp_valid.
- locked  out  1  lockout active.
- fail_count  out  $clog2(MAX_FAILS+1)  current consecutive-failure count.

## Operation
- States: IDLE, WAIT_CMP, HOLD, RESPOND, LOCKOUT.
- A single down-counter `timer` serves both latency and lockout.
  - Width: $clog2(max(RESP_LATENCY, LOCKOUT_CYCLES)+1).
  - Decrements by 1 per cycle, never below 0.
- IDLE
  - req_ready=1.
  - On req_valid=1 (acceptance): timer←RESP_LATENCY-1, match_q←0, next state WAIT_CMP.
- WAIT_CMP
  - cmp_start=1 in the first cycle of this state only.
  - On cmp_done=1: match_q←cmp_match, go to HOLD.
  - If timer reaches 0 with no cmp_done: match_q stays 0 (timeout counts as a failure), go to RESPOND.
- HOLD
  - Wait until timer=0, then go to RESPOND.
  - Any cmp_done arriving here is ignored.
- RESPOND (one cycle)
  - resp_valid=1, resp_grant=match_q.
  - On grant: fail_count←0, go to IDLE.
  - On deny: fail_count←fail_count+1, saturating at MAX_FAILS.
  - If the new fail_count equals MAX_FAILS: timer←LOCKOUT_CYCLES-1, go to LOCKOUT. Otherwise go to IDLE.
- LOCKOUT
  - locked=1, req_ready=0.
  - At timer=0: fail_count←0, locked drops, go to IDLE.
- req_ready=0 in every state except IDLE. Requests presented then are not accepted and upstream holds them.
- Outside WAIT_CMP, cmp_done and cmp_match are ignored.

## Timing
- Reset (reset_n low, asynchronous):
  - State IDLE, timer=0, match_q=0, fail_count=0.
  - resp_valid=0, resp_grant=0, cmp_start=0, locked=0.
  - req_ready is forced to 0 while reset_n is low and rises in the first cycle after release.
- Reset mid-operation aborts the request with no response and clears any lockout.
- Handshake: acceptance happens at edge k when req_valid=1 and req_ready=1.
  - cmp_start is high during the cycle after edge k.
  - resp_valid is high exactly during the cycle after edge k+RESP_LATENCY, for both grant and deny.
- resp_grant equals match_q in the RESPOND cycle and is 0 in every other cycle.
- Earliest next acceptance is the edge that ends the RESPOND cycle (req_ready=1 in the following IDLE cycle).
- Lockout: locked is high for exactly LOCKOUT_CYCLES cycles, starting in the cycle after RESPOND. req_ready returns the cycle after locked falls.
- If cmp_done=1 in the same cycle that timer reaches 0 in WAIT_CMP, cmp_match is captured (done wins) and the response still issues at the fixed cycle.
- Response time is independent of cmp_match value, cmp_done arrival cycle, and timeout.

## Test plan
- Reset with req_valid=1 held: all outputs 0 during reset. Accept at first edge after release. cmp_start one cycle later. resp_valid exactly 40 cycles after acceptance.
- Match, cmp_done 9 cycles after cmp_start: resp_valid at acceptance+40, resp_grant=1, fail_count=0.
- Mismatch with cmp_done 2 cycles after cmp_start, then match with cmp_done 30 cycles after cmp_start: both responses at acceptance+40. fail_count goes 1 then 0.
- Three consecutive mismatches: fail_count 1,2,3. locked=1 for exactly 1024 cycles, req_ready=0 throughout with req_valid held. Next acceptance on the first cycle after lockout, with fail_count=0.
- cmp_done never asserted: deny at acceptance+40, fail_count+1. A cmp_done=1 with cmp_match=1 injected during the following IDLE cycle is ignored.
- reset_n pulsed low mid-WAIT_CMP and mid-LOCKOUT: no resp_valid, immediate return to IDLE, locked=0, fail_count=0.
